// File: rtl/bp_fe_lce_resp_serializer_pkg.sv
// Shared types and helpers for the LCE->CCE response serializer.
package bp_fe_lce_resp_serializer_pkg;

  // LCE->CCE response message types
  typedef enum logic [3:0] {
    e_lce_cce_sync_ack    = 4'd0,
    e_lce_cce_inv_ack     = 4'd1,
    e_lce_cce_coh_ack     = 4'd2,
    e_lce_cce_resp_wb     = 4'd3,
    e_lce_cce_resp_null_wb = 4'd4
  } bp_lce_cce_resp_type_e;

  // Packed response header: type, address, source and destination ids (70 bits)
  typedef struct packed {
    bp_lce_cce_resp_type_e msg_type;
    logic [39:0]           addr;
    logic [12:0]           src_id;
    logic [12:0]           dst_id;
  } bp_lce_cce_resp_s;

  localparam int lce_cce_resp_hdr_width_lp = $bits(bp_lce_cce_resp_s);

  // Only a real writeback carries a cache-block payload
  function automatic logic resp_has_data(input bp_lce_cce_resp_type_e t);
    return (t == e_lce_cce_resp_wb);
  endfunction

  // Number of flits needed to carry 'bits' bits on a 'flit_w'-bit link
  function automatic int flit_count(input int bits, input int flit_w);
    return (bits + flit_w - 1) / flit_w;
  endfunction

  // Counter width for 'n' flits, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_fe_lce_resp_serializer_flit_mux.sv
// Selects one flit-wide slice of {data, zero-padded hdr} by phase and slice index.
module bp_fe_lce_resp_serializer_flit_mux
  import bp_fe_lce_resp_serializer_pkg::*;
#(
  parameter int hdr_width_p  = 70,
  parameter int data_width_p = 512,
  parameter int flit_width_p = 128,
  parameter int cnt_width_p  = 2
) (
  input  logic [hdr_width_p-1:0]  hdr_i,
  input  logic [data_width_p-1:0] data_i,
  input  logic                    en_i,
  input  logic                    sel_data_i,
  input  logic [cnt_width_p-1:0]  cnt_i,
  output logic [flit_width_p-1:0] flit_o
);

  localparam int hdr_flits_lp     = flit_count(hdr_width_p, flit_width_p);
  localparam int data_flits_lp    = data_width_p / flit_width_p;
  localparam int hdr_pad_width_lp = hdr_flits_lp * flit_width_p;

  // Header bits above hdr_width_p in the last header flit read as zero
  logic [hdr_pad_width_lp-1:0] w_hdr_pad;
  assign w_hdr_pad = hdr_pad_width_lp'(hdr_i);

  // Slice select; output is forced to zero when no flit is being presented
  always_comb begin
    flit_o = '0;
    if (en_i) begin
      if (sel_data_i) begin
        for (int k = 0; k < data_flits_lp; k++)
          if (cnt_i == cnt_width_p'(k)) flit_o = data_i[k*flit_width_p +: flit_width_p];
      end else begin
        for (int k = 0; k < hdr_flits_lp; k++)
          if (cnt_i == cnt_width_p'(k)) flit_o = w_hdr_pad[k*flit_width_p +: flit_width_p];
      end
    end
  end

endmodule

// File: rtl/bp_fe_lce_resp_serializer.sv
// Serializes one LCE->CCE response (header, then payload for writebacks) into link flits.
//
// Handshakes: a transfer happens on a rising clk_i edge where valid and ready are both 1.
// resp_ready_o depends only on state; once flit_v_o rises, flit_o/flit_last_o hold until
// flit_ready_i, and flit_v_o only drops after a handshake or on reset.
module bp_fe_lce_resp_serializer
  import bp_fe_lce_resp_serializer_pkg::*;
#(
  parameter int hdr_width_p  = 70,
  parameter int data_width_p = 512,
  parameter int flit_width_p = 128
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [hdr_width_p-1:0]  resp_hdr_i,
  input  logic [data_width_p-1:0] resp_data_i,
  input  logic                    resp_has_data_i,
  input  logic                    resp_v_i,
  output logic                    resp_ready_o,
  output logic [flit_width_p-1:0] flit_o,
  output logic                    flit_last_o,
  output logic                    flit_v_o,
  input  logic                    flit_ready_i,
  output logic [1:0]              dbg_state_o
);

  localparam int hdr_flits_lp  = flit_count(hdr_width_p, flit_width_p);
  localparam int data_flits_lp = data_width_p / flit_width_p;
  localparam int max_flits_lp  = (hdr_flits_lp > data_flits_lp) ? hdr_flits_lp : data_flits_lp;
  localparam int cnt_width_lp  = cnt_width(max_flits_lp);
  localparam logic [cnt_width_lp-1:0] hdr_last_lp  = cnt_width_lp'(hdr_flits_lp - 1);
  localparam logic [cnt_width_lp-1:0] data_last_lp = cnt_width_lp'(data_flits_lp - 1);

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_hdr  = 2'd1,
    e_data = 2'd2
  } state_e;

  state_e                    r_state, w_state_n;
  logic [cnt_width_lp-1:0]   r_cnt, w_cnt_n;
  logic                      w_capture;
  logic [hdr_width_p-1:0]    r_hdr;
  logic [data_width_p-1:0]   r_data;
  logic                      r_has_data;
  logic                      w_flit_hs;

  assign w_flit_hs   = flit_v_o & flit_ready_i;
  assign dbg_state_o = r_state;

  // State and slice counter
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= e_idle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Message capture registers, loaded only on acceptance
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_hdr      <= '0;
      r_data     <= '0;
      r_has_data <= 1'b0;
    end else if (w_capture) begin
      r_hdr      <= resp_hdr_i;
      r_data     <= resp_data_i;
      r_has_data <= resp_has_data_i;
    end
  end

  // Next-state, counter and handshake outputs
  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_capture    = 1'b0;
    resp_ready_o = 1'b0;
    flit_v_o     = 1'b0;
    flit_last_o  = 1'b0;
    case (r_state)
      e_idle: begin
        resp_ready_o = ~reset_i;
        if (resp_v_i && !reset_i) begin
          w_capture = 1'b1;
          w_state_n = e_hdr;
          w_cnt_n   = '0;
        end
      end
      e_hdr: begin
        flit_v_o    = 1'b1;
        flit_last_o = (r_cnt == hdr_last_lp) && !r_has_data;
        if (w_flit_hs) begin
          if (r_cnt == hdr_last_lp) begin
            w_cnt_n   = '0;
            w_state_n = r_has_data ? e_data : e_idle;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end
      e_data: begin
        flit_v_o    = 1'b1;
        flit_last_o = (r_cnt == data_last_lp);
        if (w_flit_hs) begin
          if (r_cnt == data_last_lp) begin
            w_cnt_n   = '0;
            w_state_n = e_idle;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_n = e_idle;
        w_cnt_n   = '0;
      end
    endcase
  end

  bp_fe_lce_resp_serializer_flit_mux #(
    .hdr_width_p (hdr_width_p),
    .data_width_p(data_width_p),
    .flit_width_p(flit_width_p),
    .cnt_width_p (cnt_width_lp)
  ) u_flit_mux (
    .hdr_i     (r_hdr),
    .data_i    (r_data),
    .en_i      (flit_v_o),
    .sel_data_i(r_state == e_data),
    .cnt_i     (r_cnt),
    .flit_o    (flit_o)
  );

  // Parameter sanity and flit hold while stalled
  a_params: assert property (@(posedge clk_i)
    (flit_width_p > 0) && ((data_width_p % flit_width_p) == 0));

  a_flit_hold: assert property (@(posedge clk_i) disable iff (reset_i)
    (flit_v_o && !flit_ready_i) |=> (flit_v_o && $stable(flit_o) && $stable(flit_last_o)));

endmodule

// File: tb/tb_bp_fe_lce_resp_serializer.sv
// Scoreboard bench for the LCE response serializer.
module tb_bp_fe_lce_resp_serializer;

  localparam int HW  = 70;
  localparam int DW  = 512;
  localparam int FW  = 128;
  localparam int HW2 = 130;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_i = 1'b1;

  // ---------------- DUT (70-bit header) ----------------
  logic [HW-1:0] resp_hdr_i = '0;
  logic [DW-1:0] resp_data_i = '0;
  logic          resp_has_data_i = 1'b0;
  logic          resp_v_i = 1'b0;
  logic          resp_ready_o;
  logic [FW-1:0] flit_o;
  logic          flit_last_o;
  logic          flit_v_o;
  logic          flit_ready_i = 1'b1;
  logic [1:0]    dbg_state_o;

  bp_fe_lce_resp_serializer #(.hdr_width_p(HW), .data_width_p(DW), .flit_width_p(FW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .resp_hdr_i(resp_hdr_i), .resp_data_i(resp_data_i), .resp_has_data_i(resp_has_data_i),
    .resp_v_i(resp_v_i), .resp_ready_o(resp_ready_o),
    .flit_o(flit_o), .flit_last_o(flit_last_o), .flit_v_o(flit_v_o),
    .flit_ready_i(flit_ready_i), .dbg_state_o(dbg_state_o)
  );

  // ---------------- DUT (130-bit header) ----------------
  logic [HW2-1:0] h2_hdr = '0;
  logic [DW-1:0]  h2_data = '0;
  logic           h2_has_data = 1'b0;
  logic           h2_v = 1'b0;
  logic           h2_ready;
  logic [FW-1:0]  h2_flit;
  logic           h2_last;
  logic           h2_flit_v;
  logic           h2_flit_ready = 1'b1;
  logic [1:0]     h2_dbg;

  bp_fe_lce_resp_serializer #(.hdr_width_p(HW2), .data_width_p(DW), .flit_width_p(FW)) dut130 (
    .clk_i(clk), .reset_i(reset_i),
    .resp_hdr_i(h2_hdr), .resp_data_i(h2_data), .resp_has_data_i(h2_has_data),
    .resp_v_i(h2_v), .resp_ready_o(h2_ready),
    .flit_o(h2_flit), .flit_last_o(h2_last), .flit_v_o(h2_flit_v),
    .flit_ready_i(h2_flit_ready), .dbg_state_o(h2_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [FW:0] exp_q[$];   // {last, flit}
  int n_tests = 0;
  int n_fail  = 0;
  int ready_mode = 0;      // 0: always ready, 1: 1,0,0 pattern, 2: random
  int cyc = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected flits for a message; n_data < 4 models a message cut short by reset
  task automatic push_msg(input logic [HW-1:0] h, input logic [DW-1:0] d, input logic hd,
                          input int n_data);
    logic [FW-1:0] hf;
    hf = '0;
    hf[HW-1:0] = h;
    exp_q.push_back({~hd, hf});
    if (hd)
      for (int k = 0; k < n_data; k++)
        exp_q.push_back({(k == 3), d[k*FW +: FW]});
  endtask

  // ---------------- link ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0:       flit_ready_i = 1'b1;
        1:       flit_ready_i = ((cyc % 3) == 0);
        default: flit_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- output monitor ----------------
  logic        prev_stall = 1'b0;
  logic [FW:0] prev_flit = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset_i) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_v", 256'(flit_v_o), 256'(1'b1));
          check("hold_flit", 256'({flit_last_o, flit_o}), 256'(prev_flit));
        end
        if (flit_v_o && flit_ready_i) begin
          check("q_nonempty", 256'(exp_q.size() != 0), 256'(1'b1));
          if (exp_q.size() != 0) check("flit", 256'({flit_last_o, flit_o}), 256'(exp_q.pop_front()));
        end
        prev_stall = flit_v_o && !flit_ready_i;
        prev_flit  = {flit_last_o, flit_o};
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [HW-1:0] h, input logic [DW-1:0] d, input logic hd);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (resp_ready_o) begin
        resp_hdr_i = h; resp_data_i = d; resp_has_data_i = hd; resp_v_i = 1'b1;
        @(posedge clk);
        #1 resp_v_i = 1'b0;
        ok = 1'b1;
      end
    end
    check("accept", 256'(ok), 256'(1'b1));
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 256'(exp_q.size()), 256'(0));
    @(negedge clk);
  endtask

  function automatic logic [HW-1:0] rand_hdr();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[HW-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  // ---------------- stimulus ----------------
  logic [HW-1:0]  h;
  logic [DW-1:0]  d;
  logic [HW2-1:0] hb;
  logic [159:0]   tmp;
  logic [FW-1:0]  e2;
  logic           hd;

  initial begin
    // reset values while reset is held
    #1;
    check("rst_v", 256'(flit_v_o), 256'(0));
    check("rst_last", 256'(flit_last_o), 256'(0));
    check("rst_flit", 256'(flit_o), 256'(0));
    check("rst_ready", 256'(resp_ready_o), 256'(0));
    check("rst_state", 256'(dbg_state_o), 256'(0));
    repeat (2) @(negedge clk);
    reset_i = 1'b0;

    // 1: inv-ack, single header flit with last, one cycle after accept
    ready_mode = 0;
    h = 70'h2A_DEAD_BEEF;
    push_msg(h, '0, 1'b0, 0);
    send(h, '0, 1'b0);
    @(negedge clk);
    check("t1_lat_v", 256'(flit_v_o), 256'(1));
    check("t1_last", 256'(flit_last_o), 256'(1));
    @(negedge clk);
    check("t1_ready_back", 256'(resp_ready_o), 256'(1));
    drain();

    // 2: writeback, slice k = k, five back-to-back flits
    h = rand_hdr();
    d = {128'd3, 128'd2, 128'd1, 128'd0};
    push_msg(h, d, 1'b1, 4);
    send(h, d, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t2_v", 256'(flit_v_o), 256'(1));
    end
    @(negedge clk);
    check("t2_v_end", 256'(flit_v_o), 256'(0));
    drain();

    // 3: writeback with stalling link
    ready_mode = 1;
    h = rand_hdr(); d = rand_data();
    push_msg(h, d, 1'b1, 4);
    send(h, d, 1'b1);
    drain();
    ready_mode = 0;
    @(negedge clk);

    // 4: 130-bit header, two header flits, zero-padded second flit
    tmp = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    hb = tmp[HW2-1:0];
    h2_hdr = hb; h2_v = 1'b1;
    @(posedge clk);
    #1 h2_v = 1'b0;
    @(negedge clk);
    check("t4_f0_v", 256'(h2_flit_v), 256'(1));
    check("t4_f0", 256'({h2_last, h2_flit}), 256'({1'b0, hb[127:0]}));
    @(negedge clk);
    e2 = '0;
    e2[1:0] = hb[129:128];
    check("t4_f1_v", 256'(h2_flit_v), 256'(1));
    check("t4_f1", 256'({h2_last, h2_flit}), 256'({1'b1, e2}));
    @(negedge clk);
    check("t4_done_v", 256'(h2_flit_v), 256'(0));
    check("t4_ready", 256'(h2_ready), 256'(1));

    // 5: held resp_v_i for 3 header-only messages: accept every other cycle
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("t5_ready", 256'(resp_ready_o), 256'((c % 2) == 0));
      check("t5_v", 256'(flit_v_o), 256'((c % 2) == 1));
      if (resp_ready_o) begin
        h = rand_hdr();
        resp_hdr_i = h; resp_has_data_i = 1'b0; resp_v_i = 1'b1;
        push_msg(h, '0, 1'b0, 0);
      end
    end
    @(negedge clk);
    resp_v_i = 1'b0;
    drain();

    // 6: asynchronous reset while data flit 2 is presented
    h = rand_hdr(); d = rand_data();
    push_msg(h, d, 1'b1, 3);
    send(h, d, 1'b1);
    repeat (4) @(negedge clk);
    #2 reset_i = 1'b1;
    #1;
    check("t6_v_rst", 256'(flit_v_o), 256'(0));
    check("t6_ready_rst", 256'(resp_ready_o), 256'(0));
    check("t6_state_rst", 256'(dbg_state_o), 256'(0));
    check("t6_q_empty", 256'(exp_q.size()), 256'(0));
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    check("t6_ready_after", 256'(resp_ready_o), 256'(1));
    h = rand_hdr(); d = rand_data();
    push_msg(h, d, 1'b1, 4);
    send(h, d, 1'b1);
    drain();

    // random mix with random link backpressure
    ready_mode = 2;
    for (int m = 0; m < 10; m++) begin
      h = rand_hdr(); d = rand_data(); hd = 1'($urandom_range(0, 1));
      push_msg(h, d, hd, 4);
      send(h, d, hd);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
